// File: rtl/zpg_pkg.sv
// Shared types and defaults for the zero-pattern generator.
// Optional ordinal output is enabled with macro ZPG_INDEX_EN.
package zpg_pkg;

    localparam int ZPG_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HOLD
    } zpg_state_t;

endpackage

// File: rtl/byte_zero_count.sv
// Combinational count of zero bits in a DATA_W-bit word.
module byte_zero_count
    import zpg_pkg::*;
#(
    parameter  int DATA_W = ZPG_DATA_W,
    localparam int ZW     = $clog2(DATA_W + 1)
) (
    input  logic [DATA_W-1:0] data,
    output logic [ZW-1:0]     zeros
);

    always_comb begin
        zeros = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (!data[i]) begin
                zeros = zeros + ZW'(1);
            end
        end
    end

endmodule

// File: rtl/zero_pattern_gen.sv
// Enumerates, in ascending order, every DATA_W-bit word with a requested number of zero bits.
// Defining ZPG_INDEX_EN adds the idx output carrying each word's ordinal in the sequence.
module zero_pattern_gen
    import zpg_pkg::*;
#(
    parameter  int DATA_W = ZPG_DATA_W,
    localparam int ZW     = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ZW-1:0]     zcount,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] dout,
    output logic              last,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef ZPG_INDEX_EN
    ,
    output logic [DATA_W-1:0] idx
`endif
);

    localparam logic [ZW-1:0] ZMAX = ZW'(DATA_W);

    zpg_state_t        state, state_next;
    logic [DATA_W-1:0] cand, cand_next;
    logic [DATA_W-1:0] dout_next;
    logic [ZW-1:0]     zlat, zlat_next;
    logic              done_next, err_next;
    logic [ZW-1:0]     cand_zeros;
    logic [DATA_W-1:0] last_word;
    logic              is_last;

    byte_zero_count #(.DATA_W(DATA_W)) u_zero_count (
        .data  (cand),
        .zeros (cand_zeros)
    );

    // Highest word with zlat zeros; a shift by the full width yields 0 for zlat == DATA_W.
    assign last_word = {DATA_W{1'b1}} << zlat;
    assign is_last   = (dout == last_word);

    assign out_valid = (state == HOLD);
    assign last      = (state == HOLD) && is_last;
    assign busy      = (state != IDLE);

`ifdef ZPG_INDEX_EN
    logic [DATA_W-1:0] idx_q, idx_next;
    assign idx = idx_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cand_next  = cand;
        dout_next  = dout;
        zlat_next  = zlat;
        done_next  = 1'b0;
        err_next   = 1'b0;
`ifdef ZPG_INDEX_EN
        idx_next   = idx_q;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    if (zcount > ZMAX) begin
                        err_next = 1'b1;
                    end else begin
                        zlat_next  = zcount;
                        cand_next  = '0;
                        state_next = SCAN;
`ifdef ZPG_INDEX_EN
                        idx_next   = '0;
`endif
                    end
                end
            end
            SCAN: begin
                if (cand_zeros == zlat) begin
                    dout_next  = cand;
                    state_next = HOLD;
                end else begin
                    cand_next = cand + DATA_W'(1);
                end
            end
            HOLD: begin
                // The last word is the numerically largest match, so the candidate never wraps.
                if (out_ready) begin
`ifdef ZPG_INDEX_EN
                    idx_next = idx_q + DATA_W'(1);
`endif
                    if (is_last) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        cand_next  = cand + DATA_W'(1);
                        state_next = SCAN;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand <= '0;
            dout <= '0;
            zlat <= '0;
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            cand <= cand_next;
            dout <= dout_next;
            zlat <= zlat_next;
            done <= done_next;
            err  <= err_next;
        end
    end

`ifdef ZPG_INDEX_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_next;
        end
    end
`endif

endmodule
